// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Optional build macro used by dependents: REGFILE_WB_PENDING_EN.
package regfile_pkg;
  localparam int REG_AW   = 4;
  localparam int REG_DW   = 16;
  localparam int NUM_REGS = 16;
  localparam logic [REG_AW-1:0] ZERO_REG = 4'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [REG_DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO holding write-back requests for one producer.
// With REGFILE_WB_PENDING_EN defined it also exposes its slots and their occupancy.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 20,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_count,
  output logic [W-1:0]  o_head
`ifdef REGFILE_WB_PENDING_EN
  , output logic [DEPTH-1:0][W-1:0] o_entries
  , output logic [DEPTH-1:0]        o_slot_valid
`endif
);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

`ifdef REGFILE_WB_PENDING_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off           = PW'(g) - r_rd_ptr;
    assign o_slot_valid[g] = ({1'b0, w_off} < r_count);
    assign o_entries[g]    = r_mem[g];
  end
`endif
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: two producer FIFOs, round-robin arbiter, registered RF write port.
// Define REGFILE_WB_PENDING_EN to add the pending[15:0] per-register in-flight mask.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_dst,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_dst,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] DstReg,
  output logic          WriteReg,
  output logic [DW-1:0] DstData,
  output logic          idle
`ifdef REGFILE_WB_PENDING_EN
  , output logic [NUM_REGS-1:0] pending
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = $bits(wb_req_t);

  wb_req_t       w_a_req, w_b_req, w_a_head, w_b_head;
  logic          w_a_full, w_b_full, w_a_empty, w_b_empty;
  logic [PW:0]   w_a_count, w_b_count;
  logic          w_a_push, w_b_push, w_grant_a, w_grant_b;
  logic          r_last_b;
  logic          r_write;
  logic [AW-1:0] r_dst;
  logic [DW-1:0] r_data;

  // Handshake: ready reflects only the registered occupancy (never a same-cycle pop);
  // a request transfers on a rising edge where valid and ready are both high.
  // Accepted writes to the zero register complete the handshake but are dropped.
  assign a_ready  = ~w_a_full;
  assign b_ready  = ~w_b_full;
  assign w_a_push = a_valid & a_ready & (a_dst != ZERO_REG);
  assign w_b_push = b_valid & b_ready & (b_dst != ZERO_REG);
  assign w_a_req  = '{dst: a_dst, data: a_data};
  assign w_b_req  = '{dst: b_dst, data: b_data};

`ifdef REGFILE_WB_PENDING_EN
  wb_req_t [DEPTH-1:0] w_a_entries, w_b_entries;
  logic    [DEPTH-1:0] w_a_slot_valid, w_b_slot_valid;
`endif

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .i_push(w_a_push), .i_pop(w_grant_a), .i_din(w_a_req),
    .o_full(w_a_full), .o_empty(w_a_empty), .o_count(w_a_count), .o_head(w_a_head)
`ifdef REGFILE_WB_PENDING_EN
    , .o_entries(w_a_entries), .o_slot_valid(w_a_slot_valid)
`endif
  );

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .i_push(w_b_push), .i_pop(w_grant_b), .i_din(w_b_req),
    .o_full(w_b_full), .o_empty(w_b_empty), .o_count(w_b_count), .o_head(w_b_head)
`ifdef REGFILE_WB_PENDING_EN
    , .o_entries(w_b_entries), .o_slot_valid(w_b_slot_valid)
`endif
  );

  // A wins when B is empty or B was granted last; B takes whatever A does not.
  assign w_grant_a = ~w_a_empty & (w_b_empty | r_last_b);
  assign w_grant_b = ~w_b_empty & ~w_grant_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
      r_write  <= 1'b0;
      r_dst    <= '0;
      r_data   <= '0;
    end else begin
      r_write <= w_grant_a | w_grant_b;
      if (w_grant_a) begin
        r_last_b <= 1'b0;
        r_dst    <= w_a_head.dst;
        r_data   <= w_a_head.data;
      end else if (w_grant_b) begin
        r_last_b <= 1'b1;
        r_dst    <= w_b_head.dst;
        r_data   <= w_b_head.data;
      end
    end
  end

  assign WriteReg = r_write;
  assign DstReg   = r_dst;
  assign DstData  = r_data;
  assign idle     = (w_a_count == '0) & (w_b_count == '0) & ~r_write;

`ifdef REGFILE_WB_PENDING_EN
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_a_slot_valid[i]) pending[w_a_entries[i].dst] = 1'b1;
      if (w_b_slot_valid[i]) pending[w_b_entries[i].dst] = 1'b1;
    end
    if (r_write) pending[r_dst] = 1'b1;
    pending[ZERO_REG] = 1'b0;
  end
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: expected writes queued at issue, checked by a monitor.
// Pending-mask checks are compiled in when REGFILE_WB_PENDING_EN is defined.
module tb_regfile_wb_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_dst = '0, b_dst = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, WriteReg, idle;
  logic [AW-1:0] DstReg;
  logic [DW-1:0] DstData;
`ifdef REGFILE_WB_PENDING_EN
  logic [15:0]   pending;
`endif

  regfile_wb_ctrl #(.DEPTH(2), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_dst(a_dst), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dst(b_dst), .b_data(b_data),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData), .idle(idle)
`ifdef REGFILE_WB_PENDING_EN
    , .pending(pending)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && WriteReg) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got dst=%0d data=0x%0h, expected no write", DstReg, DstData);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_dst_data", {12'h0, DstReg, DstData}, {12'h0, mon_exp});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_dst = '0; b_dst = '0; a_data = '0; b_data = '0;
  endtask

  task automatic set_a(input logic [AW-1:0] d, input logic [DW-1:0] v);
    a_valid = 1'b1; a_dst = d; a_data = v;
  endtask

  task automatic set_b(input logic [AW-1:0] d, input logic [DW-1:0] v);
    b_valid = 1'b1; b_dst = d; b_data = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
  endtask

  logic [1:0] bp_ready_tab [4];

  initial begin
    clear_inputs();
    do_reset();

    // reset values
    check("rst_writereg", WriteReg, 0);
    check("rst_dstreg", DstReg, 0);
    check("rst_dstdata", DstData, 0);
    check("rst_ready", {a_ready, b_ready}, 2'b11);
    check("rst_idle", idle, 1);

    // single A write
    set_a(4'd3, 16'h1234);
    exp_q.push_back({4'd3, 16'h1234});
    tick(); clear_inputs();
    check("single_wr_e1", WriteReg, 0);
    check("single_idle_e1", idle, 0);
    tick();
    check("single_wr_e2", WriteReg, 1);
    tick();
    check("single_wr_e3", WriteReg, 0);
    check("single_idle_e3", idle, 1);

    // R0 drop
    set_b(4'd0, 16'hFFFF);
    check("r0_b_ready", b_ready, 1);
    tick(); clear_inputs();
    check("r0_wr_e1", WriteReg, 0);
    check("r0_idle_e1", idle, 1);
    tick();
    check("r0_wr_e2", WriteReg, 0);
    check("r0_idle_e2", idle, 1);

    // contention twice, A first both times
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      set_a(4'd1, 16'hAAAA);
      set_b(4'd2, 16'hBBBB);
      exp_q.push_back({4'd1, 16'hAAAA});
      exp_q.push_back({4'd2, 16'hBBBB});
      tick(); clear_inputs();
      tick();
      check("cont_first_dst", DstReg, 1);
      tick();
      check("cont_second_dst", DstReg, 2);
      check("cont_second_wr", WriteReg, 1);
      tick();
      check("cont_done_wr", WriteReg, 0);
    end

    // backpressure: new A and B request each cycle for 4 cycles
    bp_ready_tab[0] = 2'b11; bp_ready_tab[1] = 2'b11;
    bp_ready_tab[2] = 2'b10; bp_ready_tab[3] = 2'b01;
    exp_q.push_back({4'd1,  16'hA001});
    exp_q.push_back({4'd9,  16'hB001});
    exp_q.push_back({4'd2,  16'hA002});
    exp_q.push_back({4'd10, 16'hB002});
    exp_q.push_back({4'd3,  16'hA003});
    exp_q.push_back({4'd12, 16'hB004});
    for (int k = 1; k <= 4; k++) begin
      set_a(AW'(k), 16'hA000 + DW'(k));
      set_b(AW'(8 + k), 16'hB000 + DW'(k));
      check("bp_ready", {a_ready, b_ready}, bp_ready_tab[k-1]);
      tick();
    end
    clear_inputs();
    repeat (4) tick();
    check("bp_idle", idle, 1);
    check("bp_drained", exp_q.size(), 0);

    // async reset mid-stream
    set_a(4'd4, 16'h4444); set_b(4'd12, 16'hCCCC);
    exp_q.push_back({4'd4, 16'h4444});
    tick();
    set_a(4'd6, 16'h6666); set_b(4'd13, 16'hDDDD);
    tick();
    check("mid_wr_e2", WriteReg, 1);
    clear_inputs();
    set_a(4'd7, 16'h7777);
    tick(); clear_inputs();
    check("mid_wr_e3", WriteReg, 1);
    check("mid_ready_e3", {a_ready, b_ready}, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wr", WriteReg, 0);
    check("mid_rst_idle", idle, 1);
    @(posedge clk);
    #4 rst_n = 1'b1;
    tick();
    check("mid_rel_idle", idle, 1);
    check("mid_rel_ready", {a_ready, b_ready}, 2'b11);
    repeat (4) tick();
    check("mid_no_writes", WriteReg, 0);
    check("mid_idle_after", idle, 1);

`ifdef REGFILE_WB_PENDING_EN
    check("pend_reset", pending, 16'h0000);
    set_a(4'd5, 16'h5555); set_b(4'd9, 16'h9999);
    exp_q.push_back({4'd5, 16'h5555});
    exp_q.push_back({4'd9, 16'h9999});
    tick(); clear_inputs();
    check("pend_e1", pending, 16'h0220);
    tick();
    check("pend_e2", pending, 16'h0220);
    tick();
    check("pend_e3", pending, 16'h0200);
    tick();
    check("pend_e4", pending, 16'h0000);
    set_a(4'd0, 16'h0BAD);
    tick(); clear_inputs();
    check("pend_r0", pending, 16'h0000);
    tick();
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
